// File: rtl/ws2812_pkg.sv
// Shared state encoding, pixel layout and timing helpers for the WS2812 receive path.
package ws2812_pkg;

    typedef enum logic [1:0] {
        WAIT_RESET = 2'd0,
        IDLE       = 2'd1,
        HIGH       = 2'd2,
        LOW        = 2'd3
    } rx_state_t;

    localparam int unsigned PIXEL_BITS = 24;
    localparam int unsigned G_POS      = 16;
    localparam int unsigned R_POS      = 8;
    localparam int unsigned B_POS      = 0;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    // ceil(clk_hz * t_ns / 1e9)
    function automatic int unsigned ns_to_cycles(input longint unsigned clk_hz,
                                                 input longint unsigned t_ns);
        return 32'((clk_hz * t_ns + 64'd999_999_999) / 64'd1_000_000_000);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous line, plus rise/fall pulses of the
// synchronized level.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level  = sync_q;
    assign rise_c = sync_q & ~prev_q;
    assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire decoder: rebuilds GRB pixels, reports frame latch and timing errors.
// Define WS2812_RX_PASSTHRU_EN to forward the bits beyond NUM_LEDS pixels on DO.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned SYSTEM_CLOCK = 50_000_000,
    parameter int unsigned NUM_LEDS     = 8,
    parameter int unsigned T1_THRESH_NS = 600,
    parameter int unsigned TMIN_HIGH_NS = 100,
    parameter int unsigned TMAX_HIGH_NS = 2000,
    parameter int unsigned RESET_US     = 40
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          DI,
    output logic [$clog2(NUM_LEDS)-1:0]   address,
    output logic [7:0]                    green_out,
    output logic [7:0]                    red_out,
    output logic [7:0]                    blue_out,
    output logic                          pixel_valid,
    output logic                          frame_done,
    output logic [$clog2(NUM_LEDS):0]     pixel_count,
    output logic                          error,
    output logic                          DO
);

    localparam int unsigned THRESH    = ns_to_cycles(64'(SYSTEM_CLOCK), 64'(T1_THRESH_NS));
    localparam int unsigned TMIN      = ns_to_cycles(64'(SYSTEM_CLOCK), 64'(TMIN_HIGH_NS));
    localparam int unsigned TMAX      = ns_to_cycles(64'(SYSTEM_CLOCK), 64'(TMAX_HIGH_NS));
    localparam int unsigned RESET_CYC = ns_to_cycles(64'(SYSTEM_CLOCK), 64'(RESET_US) * 64'd1000);
    localparam int unsigned CNT_MAX   = (RESET_CYC > TMAX + 1) ? RESET_CYC : TMAX + 1;
    localparam int unsigned CW        = $clog2(CNT_MAX + 1);
    localparam int unsigned AW        = $clog2(NUM_LEDS);
    localparam int unsigned PCW       = AW + 1;
    localparam int unsigned BCW       = $clog2(PIXEL_BITS);

    rx_state_t               state_q;
    rx_state_t               state_nxt;
    logic [CW-1:0]           cnt_q;
    logic [PIXEL_BITS-2:0]   shift_q;
    logic [BCW-1:0]          bit_cnt_q;
    logic [PCW-1:0]          pix_cnt_q;
    grb_t                    pix_q;
    grb_t                    pix_c;
    logic [PIXEL_BITS-1:0]   word_c;

    logic level;
    logic rise_c;
    logic fall_c;
    logic bit_val_c;
    logic full_c;
    logic bit_done_c;
    logic glitch_c;
    logic stuck_c;
    logic latch_c;
    logic settled_c;
    logic pix_done_c;
    logic frame_err_c;
    logic error_c;

    sync_edge_det u_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (DI),
        .level  (level),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Line events; cnt_q holds the number of same-level cycles before the current one.
    assign bit_val_c  = cnt_q >= CW'(THRESH);
    assign full_c     = pix_cnt_q == PCW'(NUM_LEDS);
    assign bit_done_c = (state_q == HIGH) && fall_c && (cnt_q >= CW'(TMIN));
    assign glitch_c   = (state_q == HIGH) && fall_c && (cnt_q < CW'(TMIN));
    assign stuck_c    = (state_q == HIGH) && level && (cnt_q == CW'(TMAX));
    assign latch_c    = (state_q == LOW) && !level && (cnt_q == CW'(RESET_CYC - 1));
    assign settled_c  = (state_q == WAIT_RESET) && !level && (cnt_q == CW'(RESET_CYC - 1));

    assign word_c = {shift_q, bit_val_c};
    assign pix_c  = '{g: word_c[G_POS +: 8], r: word_c[R_POS +: 8], b: word_c[B_POS +: 8]};

    always_ff @(posedge clk) begin
        if (reset) state_q <= WAIT_RESET;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            WAIT_RESET: if (settled_c) state_nxt = IDLE;
            IDLE:       if (rise_c) state_nxt = HIGH;
            HIGH: begin
                if (glitch_c || stuck_c) state_nxt = WAIT_RESET;
                else if (fall_c)         state_nxt = LOW;
            end
            LOW: begin
                if (rise_c)       state_nxt = HIGH;
                else if (latch_c) state_nxt = IDLE;
            end
            default: state_nxt = WAIT_RESET;
        endcase
    end

    always_comb begin
        pix_done_c  = 1'b0;
        frame_err_c = 1'b0;
        error_c     = 1'b0;
        pix_done_c  = bit_done_c && !full_c && (bit_cnt_q == BCW'(PIXEL_BITS - 1));
        frame_err_c = latch_c && (bit_cnt_q != '0);
        error_c     = glitch_c || stuck_c || frame_err_c;
    end

    // Shared run-length counter for reset-low, high and low phases.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                WAIT_RESET: cnt_q <= (level || settled_c) ? '0 : cnt_q + CW'(1);
                IDLE:       cnt_q <= rise_c ? CW'(1) : '0;
                HIGH: begin
                    if (fall_c)       cnt_q <= CW'(1);
                    else if (stuck_c) cnt_q <= '0;
                    else              cnt_q <= cnt_q + CW'(1);
                end
                LOW: begin
                    if (rise_c)       cnt_q <= CW'(1);
                    else if (latch_c) cnt_q <= '0;
                    else              cnt_q <= cnt_q + CW'(1);
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    // Bit and pixel assembly; bits past the last pixel are timed but not stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            pix_cnt_q <= '0;
        end else if (glitch_c || stuck_c || latch_c) begin
            bit_cnt_q <= '0;
            pix_cnt_q <= '0;
        end else if (bit_done_c && !full_c) begin
            shift_q <= {shift_q[PIXEL_BITS-3:0], bit_val_c};
            if (bit_cnt_q == BCW'(PIXEL_BITS - 1)) begin
                bit_cnt_q <= '0;
                pix_cnt_q <= pix_cnt_q + PCW'(1);
            end else begin
                bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q       <= '0;
            address     <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            pixel_count <= '0;
            error       <= 1'b0;
        end else begin
            pixel_valid <= pix_done_c;
            frame_done  <= latch_c;
            error       <= error_c;
            if (pix_done_c) begin
                pix_q   <= pix_c;
                address <= pix_cnt_q[AW-1:0];
            end else if (latch_c || error_c) begin
                address <= '0;
            end
            if (latch_c) pixel_count <= pix_cnt_q;
        end
    end

    assign green_out = pix_q.g;
    assign red_out   = pix_q.r;
    assign blue_out  = pix_q.b;

`ifdef WS2812_RX_PASSTHRU_EN
    logic fwd_q;
    logic do_q;

    // Behave like a chained LED: once our pixels are consumed, repeat the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_q <= 1'b0;
            do_q  <= 1'b0;
        end else begin
            do_q <= level & fwd_q;
            if (latch_c || error_c)
                fwd_q <= 1'b0;
            else if (pix_done_c && (pix_cnt_q == PCW'(NUM_LEDS - 1)))
                fwd_q <= 1'b1;
        end
    end

    assign DO = do_q;
`else
    assign DO = 1'b0;
`endif

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Decodes a WS2812 single-wire serial stream, the inverse of the existing ws2812 transmit driver, back into per-LED GRB bytes.
- Used as an on-board loopback checker for the SPI-to-NeoPixel path: GPIO DO output is wired to this block's DI input.
- Decodes each frame into numbered pixel strobes.
- Reports frame completion on latch (reset-low) detection.
- Flags malformed timing.

Parameters:
- SYSTEM_CLOCK, 50000000, clk frequency in Hz.
- NUM_LEDS, 8, pixels decoded per frame; later bits are ignored.
- T1_THRESH_NS, 600, high time >= threshold decodes '1', otherwise '0'.
- TMIN_HIGH_NS, 100, shorter high pulse is a glitch.
- TMAX_HIGH_NS, 2000, longer high pulse is a stuck-line error.
- RESET_US, 40, low time that marks latch / frame end.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- DI  in  1  asynchronous serial input; synchronized internally.
- address  out  $clog2(NUM_LEDS)  index of the pixel being presented.
- green_out  out  8  decoded green byte.
- red_out  out  8  decoded red byte.
- blue_out  out  8  decoded blue byte.
- pixel_valid  out  1  one-cycle strobe; address and colors are valid this cycle.
- frame_done  out  1  one-cycle strobe on latch detection.
- pixel_count  out  $clog2(NUM_LEDS)+1  pixels decoded in the last frame; valid with frame_done.
- error  out  1  one-cycle strobe on timing or framing error.
- DO  out  1  passthrough output (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on the port reset.
- Cycle constants:
  - Derived as ceil(SYSTEM_CLOCK * t / 1e9) cycles.
  - At default parameters: THRESH=30, TMIN=5, TMAX=100, RESET_CYC=2000.
- Input path: DI passes through a 2-flop synchronizer and then an edge detector. All latencies below are quoted from the synchronized edge.
- Reset values:
  - All outputs 0.
  - State WAIT_RESET.
  - Counters 0.
- States:
  - WAIT_RESET:
    - Line must stay low for RESET_CYC consecutive cycles; any high restarts the count.
    - Then go to IDLE, with no frame_done.
  - IDLE:
    - Rising edge -> HIGH; high counter loads 1.
  - HIGH:
    - Count high cycles.
    - Count reaching TMAX+1 -> error pulse, discard frame, go to WAIT_RESET.
    - Falling edge with count < TMIN -> error pulse, discard frame, go to WAIT_RESET.
    - Falling edge otherwise: shift bit (count >= THRESH) MSB-first into a 24-bit register, then go to LOW.
  - LOW:
    - Count low cycles.
    - Rising edge -> HIGH.
    - Count reaching RESET_CYC -> latch: frame_done pulse in that cycle, then IDLE.
- Pixel assembly:
  - Byte order is G, R, B.
  - On the 24th bit's falling edge, the next cycle drives green_out/red_out/blue_out and address, and pulses pixel_valid.
  - Colors hold until the next pixel; address then increments.
  - Once address has consumed NUM_LEDS pixels, further bits are timed and checked but not decoded: no pixel_valid, no wrap.
- Latch:
  - pixel_count = pixels decoded in the frame, saturating at NUM_LEDS.
  - If bits mod 24 != 0 (partial pixel, not counting the ignored overflow bits), error pulses together with frame_done.
  - address, bit count and pixel count then clear to 0.
  - A latch with zero bits received still pulses frame_done, with pixel_count=0.
- Simultaneous events: a latch and an error in the same cycle both pulse.
- reset asserted mid-frame: drops the frame with no frame_done, returns to WAIT_RESET.

Optional Feature:
- Macro: WS2812_RX_PASSTHRU_EN.
- Defined:
  - DO = synchronized DI, delayed one cycle, gated by fwd.
  - fwd sets on the falling edge that completes pixel NUM_LEDS-1.
  - fwd clears on latch, error, or reset.
  - This behaves like a chained WS2812: downstream LEDs receive the unconsumed bits.
- Undefined: DO is constant 0 and fwd logic is absent.

Decomposition:
- ws2812_pkg:
  - ns-to-cycles constant function.
  - State enum: WAIT_RESET, IDLE, HIGH, LOW.
  - GRB byte-position constants.
- One sub-module, sync_edge_det: 2-flop synchronizer plus rise/fall pulses.

Test Plan (50 MHz, defaults; '1'=40 high/22 low cycles, '0'=20 high/42 low cycles):
- Post-reset: hold DI low 2000 cycles, send pixel G=0xA5 R=0x3C B=0x0F, then low 2500 cycles -> pixel_valid once with address=0 and bytes as sent; frame_done with pixel_count=1, error=0.
- Full frame: 8 pixels of value i*0x111111, then latch -> 8 pixel_valid pulses with address 0..7 and correct bytes; frame_done with pixel_count=8.
- Overflow: send 10 pixels -> exactly 8 pixel_valid; pixel_count=8. With WS2812_RX_PASSTHRU_EN, DO reproduces pixels 8-9 waveform delayed 3 cycles; without it DO stays 0.
- Glitch: 3-cycle high pulse mid-pixel -> error pulse, no frame_done, no pixel_valid until WAIT_RESET satisfied; a following valid frame decodes correctly.
- Stuck high: DI high 150 cycles -> error when the high count reaches 101; state WAIT_RESET.
- Partial frame: 30 bits then latch -> one pixel_valid; frame_done and error in the same cycle; pixel_count=1.
